pc_sequencer: RTL and testbench

- Consumer end of the jump-target path: receives the 32-bit zero-extended jump target from the jump-address unit, plus branch, register-jump and return requests.
- Owns the program counter and a small return-address stack (RAS) for jal/jr-ra.
- Sits between control/hazard logic and instruction memory; the PC is word-addressed, and sequential fetch is PC+1.

---
 rtl/pc_sequencer_pkg.sv | 65 ++++++
 rtl/pc_sequencer_ras_stack.sv | 48 ++++
 rtl/pc_sequencer.sv | 86 ++++++++
 tb/tb_pc_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types for the PC sequencer: PC width, sequencer states, redirect kinds
// and the next-PC priority resolver reused by hazard/control units.
package pc_sequencer_pkg;

  localparam int PC_WIDTH = 32;

  typedef logic [PC_WIDTH-1:0] pc_t;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_STALLED,
    ST_HALTED
  } seq_state_t;

  typedef enum logic [2:0] {
    RD_NONE,
    RD_REG,
    RD_RET,
    RD_JUMP,
    RD_JAL,
    RD_BRANCH
  } redir_kind_t;

  typedef struct packed {
    redir_kind_t kind;
    pc_t         target;
  } redirect_t;

  // Priority: jr (ret pops only when the stack has something), then jump/jal,
  // then taken branch, else sequential. Orphan link/ret qualifiers fall through.
  function automatic redirect_t resolve(
    input logic jump_reg,
    input logic ret,
    input logic ras_empty,
    input pc_t  ras_top,
    input pc_t  reg_target,
    input logic jump,
    input logic link,
    input pc_t  jump_target,
    input logic branch_taken,
    input pc_t  branch_offset,
    input pc_t  pc_inc
  );
    redirect_t r;
    r.kind   = RD_NONE;
    r.target = pc_inc;
    if (jump_reg) begin
      if (ret && !ras_empty) begin
        r.kind   = RD_RET;
        r.target = ras_top;
      end else begin
        r.kind   = RD_REG;
        r.target = reg_target;
      end
    end else if (jump) begin
      r.kind   = link ? RD_JAL : RD_JUMP;
      r.target = jump_target;
    end else if (branch_taken) begin
      r.kind   = RD_BRANCH;
      r.target = pc_inc + branch_offset;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack; a push while full overwrites the oldest entry
// and sets a sticky overflow flag.
module ras_stack
  import pc_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  pc_t  push_data,
  output pc_t  top,
  output logic empty,
  output logic overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  pc_t [DEPTH-1:0]  mem;
  logic [PTR_W-1:0] ptr;
  logic [CNT_W-1:0] count;

  assign top   = mem[ptr];
  assign empty = (count == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem      <= '0;
      ptr      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (push) begin
      // wrapping the pointer is what discards the oldest entry when full
      mem[ptr + PTR_ONE] <= push_data;
      ptr                <= ptr + PTR_ONE;
      if (count == CNT_FULL) overflow <= 1'b1;
      else                   count    <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr - PTR_ONE;
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: next-PC selection, stall-time pending redirect buffer,
// halt handling and the return-address stack for jal / jr-ra.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter int          RAS_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        halt,
  input  logic        stall,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        link,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump_reg,
  input  logic [31:0] reg_target,
  input  logic        ret,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        halted,
  output logic        ras_empty,
  output logic        ras_overflow
);

  seq_state_t state;
  redirect_t  live, pend, sel;
  logic       pend_vld;
  logic       advance, push, pop;
  pc_t        pc_inc, ras_top;

  assign pc_inc = pc + pc_t'(1);

  assign live = resolve(jump_reg, ret, ras_empty, ras_top, reg_target,
                        jump, link, jump_target, branch_taken, branch_offset, pc_inc);

  // A buffered redirect beats whatever is on the inputs in the release cycle.
  assign advance = (state != ST_HALTED) && !halt && !stall;
  assign sel     = pend_vld ? pend : live;
  assign push    = advance && (sel.kind == RD_JAL);
  assign pop     = advance && (sel.kind == RD_RET);

  ras_stack #(.DEPTH(RAS_DEPTH)) u_ras (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .overflow  (ras_overflow)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_RUN;
      pc        <= RESET_PC;
      link_addr <= '0;
      halted    <= 1'b0;
      pend_vld  <= 1'b0;
      pend      <= '{kind: RD_NONE, target: '0};
    end else if (state == ST_HALTED) begin
      state <= ST_HALTED;
    end else if (halt) begin
      state    <= ST_HALTED;
      halted   <= 1'b1;
      pend_vld <= 1'b0;
      pend     <= '{kind: RD_NONE, target: '0};
    end else if (stall) begin
      // PC is held during a stall, so a captured RET target / JAL link stays valid
      state <= ST_STALLED;
      if (live.kind != RD_NONE) begin
        pend     <= live;
        pend_vld <= 1'b1;
      end
    end else begin
      state    <= ST_RUN;
      pend_vld <= 1'b0;
      pc       <= sel.target;
      if (sel.kind == RD_JAL) link_addr <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        halt = 0, stall = 0, jump = 0, link = 0, branch_taken = 0, jump_reg = 0, ret = 0;
  logic [31:0] jump_target = '0, branch_offset = '0, reg_target = '0;
  logic [31:0] pc, link_addr;
  logic        halted, ras_empty, ras_overflow;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pc_sequencer #(.RESET_PC(32'd0), .RAS_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .halt(halt), .stall(stall),
    .jump(jump), .jump_target(jump_target), .link(link),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .jump_reg(jump_reg), .reg_target(reg_target), .ret(ret),
    .pc(pc), .link_addr(link_addr), .halted(halted),
    .ras_empty(ras_empty), .ras_overflow(ras_overflow)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    halt = 0; stall = 0; jump = 0; link = 0; branch_taken = 0; jump_reg = 0; ret = 0;
    jump_target = '0; branch_offset = '0; reg_target = '0;
  endtask

  task automatic goto(input logic [31:0] t);
    clr();
    jump = 1; jump_target = t;
    step();
    clr();
  endtask

  task automatic do_reset();
    clr();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    clr();
    step(); step();
    checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc got %h exp %h", pc, 32'd0); end
    checks++; if (link_addr !== 32'd0) begin errors++; $display("FAIL reset_link got %h exp 0", link_addr); end
    checks++; if ({halted, ras_empty, ras_overflow} !== 3'b010) begin errors++;
      $display("FAIL reset_flags got %b exp 010", {halted, ras_empty, ras_overflow}); end
    reset = 0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pc !== 32'(i)) begin errors++; $display("FAIL idle_seq%0d got %h exp %h", i, pc, 32'(i)); end
    end
    goto(32'd7);
    checks++; if (pc !== 32'd7) begin errors++; $display("FAIL goto7 got %h exp 7", pc); end
    #2 reset = 1;
    #1;
    checks++; if (pc !== 32'd0) begin errors++; $display("FAIL async_reset_pc got %h exp 0", pc); end
    step();
    reset = 0;
  endtask

  task automatic test_jal_ret();
    goto(32'd5);
    jump = 1; link = 1; jump_target = 32'h40;
    step(); clr();
    checks++; if (pc !== 32'h40) begin errors++; $display("FAIL jal_pc got %h exp 40", pc); end
    checks++; if (link_addr !== 32'd6) begin errors++; $display("FAIL jal_link got %h exp 6", link_addr); end
    checks++; if (ras_empty !== 1'b0) begin errors++; $display("FAIL jal_empty got %b exp 0", ras_empty); end
    jump_reg = 1; ret = 1; reg_target = 32'h99;
    step(); clr();
    checks++; if (pc !== 32'd6) begin errors++; $display("FAIL ret_pc got %h exp 6", pc); end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty got %b exp 1", ras_empty); end
    // orphan ret without jump_reg: plain sequential
    ret = 1; link = 1;
    step(); clr();
    checks++; if (pc !== 32'd7) begin errors++; $display("FAIL orphan_qual got %h exp 7", pc); end
  endtask

  task automatic test_branch();
    goto(32'd10);
    branch_taken = 1; branch_offset = -32'sd4;
    step(); clr();
    checks++; if (pc !== 32'd7) begin errors++; $display("FAIL br_neg got %h exp 7", pc); end
    goto(32'd10);
    branch_taken = 1; branch_offset = 32'd0;
    step(); clr();
    checks++; if (pc !== 32'd11) begin errors++; $display("FAIL br_zero got %h exp 11", pc); end
    // priority: jump over branch
    jump = 1; jump_target = 32'h22; branch_taken = 1; branch_offset = 32'd100;
    step(); clr();
    checks++; if (pc !== 32'h22) begin errors++; $display("FAIL prio_jump got %h exp 22", pc); end
    // priority: jr over jump
    jump_reg = 1; reg_target = 32'hFFFF_FFFF; jump = 1; jump_target = 32'h55;
    step(); clr();
    checks++; if (pc !== 32'hFFFF_FFFF) begin errors++; $display("FAIL prio_jr got %h exp ffffffff", pc); end
    step();
    checks++; if (pc !== 32'd0) begin errors++; $display("FAIL wrap got %h exp 0", pc); end
  endtask

  task automatic test_stall();
    goto(32'd20);
    stall = 1;
    step();
    jump = 1; jump_target = 32'h100;
    step();
    jump = 0;
    step();
    checks++; if (pc !== 32'd20) begin errors++; $display("FAIL stall_hold got %h exp 14", pc); end
    stall = 0; branch_taken = 1; branch_offset = 32'd50;
    step(); clr();
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL pend_apply got %h exp 100", pc); end
    step();
    checks++; if (pc !== 32'h101) begin errors++; $display("FAIL pend_clear got %h exp 101", pc); end
    // later request overwrites buffer
    stall = 1; jump = 1; jump_target = 32'h200;
    step(); clr();
    stall = 1; jump_reg = 1; reg_target = 32'h300;
    step(); clr();
    checks++; if (pc !== 32'h101) begin errors++; $display("FAIL stall2_hold got %h exp 101", pc); end
    step();
    checks++; if (pc !== 32'h300) begin errors++; $display("FAIL pend_overwrite got %h exp 300", pc); end
  endtask

  task automatic test_ras_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      jump = 1; link = 1; jump_target = 32'(i + 1);
      step(); clr();
      if (i == 3) begin
        checks++; if (ras_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", ras_overflow); end
      end
    end
    checks++; if (ras_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ras_overflow); end
    checks++; if (link_addr !== 32'd5) begin errors++; $display("FAIL ovf_link got %h exp 5", link_addr); end
    for (int k = 0; k < 4; k++) begin
      jump_reg = 1; ret = 1; reg_target = 32'hDEAD;
      step(); clr();
      checks++; if (pc !== 32'(5 - k)) begin errors++; $display("FAIL pop%0d got %h exp %h", k, pc, 32'(5 - k)); end
    end
    checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL pop_empty got %b exp 1", ras_empty); end
    jump_reg = 1; ret = 1; reg_target = 32'h33;
    step(); clr();
    checks++; if (pc !== 32'h33) begin errors++; $display("FAIL ret_empty got %h exp 33", pc); end
    checks++; if (ras_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", ras_overflow); end
  endtask

  task automatic test_halt();
    goto(32'd9);
    halt = 1; jump = 1; jump_target = 32'h80;
    step(); clr();
    checks++; if (pc !== 32'd9) begin errors++; $display("FAIL halt_pc got %h exp 9", pc); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got %b exp 1", halted); end
    jump = 1; jump_target = 32'h50;
    step(); clr();
    branch_taken = 1; branch_offset = 32'd3;
    step(); clr();
    step();
    checks++; if (pc !== 32'd9) begin errors++; $display("FAIL halt_frozen got %h exp 9", pc); end
    #2 reset = 1;
    #1;
    checks++; if ({pc, halted, ras_overflow, ras_empty} !== {32'd0, 3'b001}) begin errors++;
      $display("FAIL halt_reset got pc=%h h=%b o=%b e=%b exp 0 0 0 1", pc, halted, ras_overflow, ras_empty); end
    step();
    reset = 0;
    step();
    checks++; if (pc !== 32'd1) begin errors++; $display("FAIL post_reset got %h exp 1", pc); end
  endtask

  initial begin
    test_reset();
    test_jal_ret();
    test_branch();
    test_stall();
    test_ras_overflow();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
